// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life generation scanner.
package gol_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam int NBR_SLOT_CNT    = 9;
    localparam int CYCLES_PER_CELL = 11;

    // Bit n set means "a cell with n live neighbours becomes/stays alive".
    localparam logic [8:0] BIRTH_MASK   = 9'b000001000;
    localparam logic [8:0] SURVIVE_MASK = 9'b000001100;

    // Apply the birth/survival masks to one cell.
    function automatic logic next_cell_state(input logic self_alive, input logic [3:0] nbr_cnt);
        logic result;
        if (nbr_cnt > 4'd8) begin
            result = 1'b0;
        end else if (self_alive) begin
            result = SURVIVE_MASK[nbr_cnt];
        end else begin
            result = BIRTH_MASK[nbr_cnt];
        end
        return result;
    endfunction

endpackage

// File: rtl/get_nbrs_address.sv
// Maps a neighbour slot (0..7) of a cell to that neighbour's address and
// flags whether the neighbour lies inside the field. Slots are laid out as
//   0 1 2
//   3 x 4
//   5 6 7
// with y increasing downward. Out-of-field or unknown slots return the cell's
// own address so the address bus always carries a legal location.
module get_nbrs_address #(
    parameter int FIELD_W = 30,
    parameter int FIELD_H = 50
) (
    input  logic [$clog2(FIELD_W)-1:0] cell_x,
    input  logic [$clog2(FIELD_H)-1:0] cell_y,
    input  logic [3:0]                 slot,
    output logic [$clog2(FIELD_W)-1:0] nbr_x,
    output logic [$clog2(FIELD_H)-1:0] nbr_y,
    output logic                       relevant
);

    localparam int XW = $clog2(FIELD_W);
    localparam int YW = $clog2(FIELD_H);
    localparam logic [XW-1:0] X_MAX = XW'(FIELD_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(FIELD_H - 1);

    logic go_left;
    logic go_right;
    logic go_up;
    logic go_down;
    logic slot_ok;
    logic x_ok;
    logic y_ok;

    // Decode the slot into a direction, check field bounds and form the address.
    always_comb begin
        go_left  = 1'b0;
        go_right = 1'b0;
        go_up    = 1'b0;
        go_down  = 1'b0;
        slot_ok  = 1'b1;
        case (slot)
            4'd0: begin go_left  = 1'b1; go_up   = 1'b1; end
            4'd1: begin go_up    = 1'b1;                 end
            4'd2: begin go_right = 1'b1; go_up   = 1'b1; end
            4'd3: begin go_left  = 1'b1;                 end
            4'd4: begin go_right = 1'b1;                 end
            4'd5: begin go_left  = 1'b1; go_down = 1'b1; end
            4'd6: begin go_down  = 1'b1;                 end
            4'd7: begin go_right = 1'b1; go_down = 1'b1; end
            default: slot_ok = 1'b0;
        endcase

        x_ok     = !(go_left && (cell_x == '0)) && !(go_right && (cell_x == X_MAX));
        y_ok     = !(go_up && (cell_y == '0)) && !(go_down && (cell_y == Y_MAX));
        relevant = slot_ok && x_ok && y_ok;

        nbr_x = cell_x;
        nbr_y = cell_y;
        if (relevant) begin
            if (go_left) begin
                nbr_x = cell_x - XW'(1);
            end else if (go_right) begin
                nbr_x = cell_x + XW'(1);
            end
            if (go_up) begin
                nbr_y = cell_y - YW'(1);
            end else if (go_down) begin
                nbr_y = cell_y + YW'(1);
            end
        end
    end

endmodule

// File: rtl/cell_updater.sv
// Scans the whole field once per i_start: for every cell in raster order it
// reads the 8 neighbours and the cell itself (9 read slots), waits one drain
// cycle for the last read, then writes the cell's next-generation state.
module cell_updater
    import gol_pkg::*;
#(
    parameter int FIELD_W = 30,
    parameter int FIELD_H = 50
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_start,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_rd_en,
    output logic [$clog2(FIELD_W)-1:0]             o_rd_x_adr,
    output logic [$clog2(FIELD_H)-1:0]             o_rd_y_adr,
    input  logic                                   i_rd_data,
    output logic                                   o_wr_en,
    output logic [$clog2(FIELD_W)-1:0]             o_wr_x_adr,
    output logic [$clog2(FIELD_H)-1:0]             o_wr_y_adr,
    output logic                                   o_wr_data,
    output logic [$clog2(FIELD_W*FIELD_H+1)-1:0]   o_alive_cnt
);

    localparam int XW = $clog2(FIELD_W);
    localparam int YW = $clog2(FIELD_H);
    localparam int AW = $clog2(FIELD_W * FIELD_H + 1);
    localparam logic [XW-1:0] X_MAX     = XW'(FIELD_W - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(FIELD_H - 1);
    localparam logic [3:0]    LAST_SLOT = 4'(NBR_SLOT_CNT - 1);

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      slot_q;
    logic [XW-1:0]   cell_x_q;
    logic [YW-1:0]   cell_y_q;
    logic [3:0]      nbr_cnt_q;
    logic            prev_rel_q;
    logic            self_q;
    logic [AW-1:0]   alive_q;

    logic [XW-1:0]   nbr_x;
    logic [YW-1:0]   nbr_y;
    logic            nbr_rel;
    logic            slot_is_self;
    logic            slot_rel;
    logic [XW-1:0]   slot_x;
    logic [YW-1:0]   slot_y;
    logic            last_cell;
    logic            next_alive;

    get_nbrs_address #(
        .FIELD_W (FIELD_W),
        .FIELD_H (FIELD_H)
    ) u_get_nbrs_address (
        .cell_x   (cell_x_q),
        .cell_y   (cell_y_q),
        .slot     (slot_q),
        .nbr_x    (nbr_x),
        .nbr_y    (nbr_y),
        .relevant (nbr_rel)
    );

    // The self slot uses the cell address directly; neighbour slots use the sub-module.
    assign slot_is_self = (slot_q == LAST_SLOT);
    assign slot_rel     = slot_is_self ? 1'b1     : nbr_rel;
    assign slot_x       = slot_is_self ? cell_x_q : nbr_x;
    assign slot_y       = slot_is_self ? cell_y_q : nbr_y;
    assign last_cell    = (cell_x_q == X_MAX) && (cell_y_q == Y_MAX);
    assign next_alive   = next_cell_state(self_q, nbr_cnt_q);
    assign o_alive_cnt  = alive_q;

    // State register; reset returns to IDLE from anywhere, even mid-scan.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and all strobes/addresses derived from the current state.
    always_comb begin
        state_d    = state_q;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_rd_en    = 1'b0;
        o_rd_x_adr = '0;
        o_rd_y_adr = '0;
        o_wr_en    = 1'b0;
        o_wr_x_adr = '0;
        o_wr_y_adr = '0;
        o_wr_data  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = READ;
                end
            end
            READ: begin
                o_busy     = 1'b1;
                o_rd_en    = slot_rel;
                o_rd_x_adr = slot_x;
                o_rd_y_adr = slot_y;
                if (slot_is_self) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                o_busy = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                o_busy     = 1'b1;
                o_wr_en    = 1'b1;
                o_wr_x_adr = cell_x_q;
                o_wr_y_adr = cell_y_q;
                o_wr_data  = next_alive;
                state_d    = last_cell ? DONE : READ;
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan datapath: slot/cell counters, neighbour accumulation and live-cell count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            slot_q     <= 4'd0;
            cell_x_q   <= '0;
            cell_y_q   <= '0;
            nbr_cnt_q  <= 4'd0;
            prev_rel_q <= 1'b0;
            self_q     <= 1'b0;
            alive_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        slot_q     <= 4'd0;
                        cell_x_q   <= '0;
                        cell_y_q   <= '0;
                        nbr_cnt_q  <= 4'd0;
                        prev_rel_q <= 1'b0;
                        self_q     <= 1'b0;
                        alive_q    <= '0;
                    end
                end
                READ: begin
                    slot_q     <= slot_is_self ? 4'd0 : slot_q + 4'd1;
                    prev_rel_q <= slot_rel && !slot_is_self;
                    if (prev_rel_q && i_rd_data) begin
                        nbr_cnt_q <= nbr_cnt_q + 4'd1;
                    end
                end
                DRAIN: begin
                    self_q <= i_rd_data;
                end
                WRITE: begin
                    if (next_alive) begin
                        alive_q <= alive_q + AW'(1);
                    end
                    slot_q     <= 4'd0;
                    nbr_cnt_q  <= 4'd0;
                    prev_rel_q <= 1'b0;
                    if (last_cell) begin
                        cell_x_q <= '0;
                        cell_y_q <= '0;
                    end else if (cell_x_q == X_MAX) begin
                        cell_x_q <= '0;
                        cell_y_q <= cell_y_q + YW'(1);
                    end else begin
                        cell_x_q <= cell_x_q + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_updater.sv
// Bench for cell_updater on a 5x5 field with a 1-cycle-latency memory.
module tb_cell_updater;

    localparam int W        = 5;
    localparam int H        = 5;
    localparam int CELLS    = W * H;
    localparam int CPC      = 11;
    localparam int SCAN_LEN = CELLS * CPC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [2:0] rd_x;
    logic [2:0] rd_y;
    logic       rd_data = 1'b0;
    logic       wr_en;
    logic [2:0] wr_x;
    logic [2:0] wr_y;
    logic       wr_data;
    logic [4:0] alive;

    bit cur_mem  [CELLS];
    bit exp_next [CELLS];

    int tests_run    = 0;
    int tests_failed = 0;

    int dxs [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int dys [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

    int         m_t = 0;
    bit         m_active = 1'b0;
    bit         m_rst_idle = 1'b1;
    int         m_alive_hold = 0;
    logic [8:0] mask_first = '0;
    logic [8:0] mask_last = '0;

    cell_updater #(
        .FIELD_W (W),
        .FIELD_H (H)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_rd_en     (rd_en),
        .o_rd_x_adr  (rd_x),
        .o_rd_y_adr  (rd_y),
        .i_rd_data   (rd_data),
        .o_wr_en     (wr_en),
        .o_wr_x_adr  (wr_x),
        .o_wr_y_adr  (wr_y),
        .o_wr_data   (wr_data),
        .o_alive_cnt (alive)
    );

    always #5 clk = ~clk;

    // Memory returns the stored cell one cycle after a strobe; garbage 1 otherwise.
    always @(posedge clk) begin
        if (rd_en && rd_x < 3'd5 && rd_y < 3'd5) begin
            rd_data <= cur_mem[int'(rd_y) * W + int'(rd_x)];
        end else begin
            rd_data <= 1'b1;
        end
    end

    task automatic check_output(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Plain Game of Life rule applied to the whole current field.
    task automatic compute_next();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int n;
                n = 0;
                for (int k = 0; k < 8; k++) begin
                    int nx, ny;
                    nx = x + dxs[k];
                    ny = y + dys[k];
                    if (nx >= 0 && nx < W && ny >= 0 && ny < H && cur_mem[ny * W + nx]) n++;
                end
                exp_next[y * W + x] = (n == 3) || (cur_mem[y * W + x] && n == 2);
            end
        end
    endtask

    function automatic int live_before(input int c);
        int s;
        s = 0;
        for (int i = 0; i < c; i++) s += int'(exp_next[i]);
        return s;
    endfunction

    // Timeline model: advance on each edge, then compare every DUT output.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_active     = 1'b0;
            m_t          = 0;
            m_alive_hold = 0;
            m_rst_idle   = 1'b1;
        end else if (m_active) begin
            if (m_t == SCAN_LEN) m_active = 1'b0;
            else m_t++;
        end else if (start) begin
            m_active     = 1'b1;
            m_t          = 0;
            m_alive_hold = 0;
            m_rst_idle   = 1'b0;
            mask_first   = '0;
            mask_last    = '0;
            compute_next();
        end
        #1;
        check_output("rd_wr_exclusive", int'(rd_en & wr_en), 0);
        if (!m_active) begin
            check_output("idle_busy", int'(busy), 0);
            check_output("idle_done", int'(done), 0);
            check_output("idle_rd_en", int'(rd_en), 0);
            check_output("idle_wr_en", int'(wr_en), 0);
            check_output("idle_alive", int'(alive), m_alive_hold);
            if (m_rst_idle) begin
                check_output("reset_addr_data",
                             int'(rd_x) + int'(rd_y) + int'(wr_x) + int'(wr_y) + int'(wr_data), 0);
            end
        end else if (m_t == SCAN_LEN) begin
            m_alive_hold = live_before(CELLS);
            check_output("done_pulse", int'(done), 1);
            check_output("done_busy", int'(busy), 0);
            check_output("done_rd_en", int'(rd_en), 0);
            check_output("done_wr_en", int'(wr_en), 0);
            check_output("done_alive", int'(alive), m_alive_hold);
        end else begin
            int c, p, cx, cy;
            c  = m_t / CPC;
            p  = m_t % CPC;
            cx = c % W;
            cy = c / W;
            check_output("scan_busy", int'(busy), 1);
            check_output("scan_done", int'(done), 0);
            check_output("scan_alive", int'(alive), live_before(c));
            if (p < 9) begin
                int ex, ey;
                bit exp_rd;
                ex = (p == 8) ? cx : cx + dxs[p];
                ey = (p == 8) ? cy : cy + dys[p];
                exp_rd = (ex >= 0 && ex < W && ey >= 0 && ey < H);
                check_output("read_rd_en", int'(rd_en), int'(exp_rd));
                check_output("read_wr_en", int'(wr_en), 0);
                check_output("read_addr_in_field", int'(rd_x < 3'd5 && rd_y < 3'd5), 1);
                if (exp_rd) begin
                    check_output("read_x", int'(rd_x), ex);
                    check_output("read_y", int'(rd_y), ey);
                end
                if (rd_en && c == 0) mask_first[p] = 1'b1;
                if (rd_en && c == CELLS - 1) mask_last[p] = 1'b1;
            end else if (p == 9) begin
                check_output("drain_rd_en", int'(rd_en), 0);
                check_output("drain_wr_en", int'(wr_en), 0);
            end else begin
                check_output("write_wr_en", int'(wr_en), 1);
                check_output("write_x", int'(wr_x), cx);
                check_output("write_y", int'(wr_y), cy);
                check_output("write_data", int'(wr_data), int'(exp_next[c]));
            end
        end
    end

    // Launch one scan, optionally re-pulse start mid-scan, and time o_done.
    task automatic apply_stimulus(input string name, input int exp_live, input bit repulse);
        int edges;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        edges = 0;
        while (edges < SCAN_LEN + 50) begin
            @(posedge clk);
            edges++;
            #2;
            if (done) break;
            start = repulse && (edges == 40);
        end
        start = 1'b0;
        check_output({name, "_done_latency"}, edges, SCAN_LEN);
        check_output({name, "_alive_cnt"}, int'(alive), exp_live);
    endtask

    function automatic int model_live();
        int s;
        s = 0;
        for (int i = 0; i < CELLS; i++) s += int'(exp_next[i]);
        return s;
    endfunction

    initial begin
        for (int i = 0; i < CELLS; i++) cur_mem[i] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_alive", int'(alive), 0);
        check_output("reset_wr_en", int'(wr_en), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] scene: all-dead field");
        apply_stimulus("dead", 0, 1'b0);
        check_output("model_dead_live", model_live(), 0);
        check_output("rd_mask_cell_0_0", int'(mask_first), 'h1D0);
        check_output("rd_mask_cell_4_4", int'(mask_last), 'h10B);
        repeat (3) @(negedge clk);

        $display("[TB] scene: vertical blinker with ignored re-start");
        cur_mem[1 * W + 2] = 1'b1;
        cur_mem[2 * W + 2] = 1'b1;
        cur_mem[3 * W + 2] = 1'b1;
        apply_stimulus("blinker", 3, 1'b1);
        check_output("model_blinker_live", model_live(), 3);
        check_output("model_blinker_1_2", int'(exp_next[2 * W + 1]), 1);
        check_output("model_blinker_2_2", int'(exp_next[2 * W + 2]), 1);
        check_output("model_blinker_3_2", int'(exp_next[2 * W + 3]), 1);
        check_output("model_blinker_2_1", int'(exp_next[1 * W + 2]), 0);
        repeat (4) @(negedge clk);
        check_output("blinker_alive_held", int'(alive), 3);

        $display("[TB] scene: reset during cell 7");
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (7 * CPC + 3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        check_output("midreset_busy", int'(busy), 0);
        check_output("midreset_alive", int'(alive), 0);
        check_output("midreset_wr_en", int'(wr_en), 0);
        check_output("midreset_rd_en", int'(rd_en), 0);
        repeat (20) @(negedge clk);

        $display("[TB] scene: 2x2 block, scan restarts at origin");
        for (int i = 0; i < CELLS; i++) cur_mem[i] = 1'b0;
        cur_mem[0]     = 1'b1;
        cur_mem[1]     = 1'b1;
        cur_mem[W]     = 1'b1;
        cur_mem[W + 1] = 1'b1;
        apply_stimulus("block", 4, 1'b0);
        check_output("model_block_live", model_live(), 4);
        check_output("model_block_1_1", int'(exp_next[W + 1]), 1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cell_updater.md
CELL_UPDATER -- requirements
Module: cell_updater

Interface
REQ-001 SHALL have parameter FIELD_W, default 30, field width in cells.
REQ-002 SHALL have parameter FIELD_H, default 50, field height in cells.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_start  input  1  start one generation scan.
REQ-006 SHALL have port o_busy  output  1  scan in progress.
REQ-007 SHALL have port o_done  output  1  one-cycle pulse at scan end.
REQ-008 SHALL have port o_rd_en  output  1  current-generation read strobe.
REQ-009 SHALL have ports o_rd_x_adr / o_rd_y_adr  output  $clog2(FIELD_W) / $clog2(FIELD_H)  read address.
REQ-010 SHALL have port i_rd_data  input  1  cell state, valid one cycle after o_rd_en.
REQ-011 SHALL have port o_wr_en  output  1  next-generation write strobe.
REQ-012 SHALL have ports o_wr_x_adr / o_wr_y_adr  output  same widths  write address.
REQ-013 SHALL have port o_wr_data  output  1  next state of the cell.
REQ-014 SHALL have port o_alive_cnt  output  $clog2(FIELD_W*FIELD_H+1)  live cells written this scan.

Function
REQ-015 SHALL use states IDLE, READ, DRAIN, WRITE, DONE.
REQ-016 IDLE: i_start=1 SHALL clear the cell counters to (0,0), clear o_alive_cnt, and go to READ.
REQ-017 i_start SHALL be ignored outside IDLE.
REQ-018 READ SHALL last exactly 9 cycles per cell, with slots 0..7 being the neighbours (0 1 2 / 3 x 4 / 5 6 7, y increasing downward) and slot 8 the cell itself.
REQ-019 A neighbour slot outside the field SHALL have o_rd_en=0, and its returned data SHALL count as dead.
REQ-020 Addresses SHALL be held stable and valid in every READ slot, including non-relevant slots.
REQ-021 DRAIN (1 cycle) SHALL capture the slot-8 data.
REQ-022 The neighbour count SHALL be 4 bits wide (0..8) and SHALL accumulate only masked i_rd_data for slots 0..7.
REQ-023 WRITE (1 cycle) SHALL assert o_wr_en with the cell address and o_wr_data = (cnt==3) | (self & cnt==2).
REQ-024 WRITE SHALL increment o_alive_cnt when o_wr_data=1.
REQ-025 After WRITE, the scan SHALL advance in raster order (x first, wrap x to 0 and y+1) and return to READ.
REQ-026 After cell (FIELD_W-1, FIELD_H-1), the FSM SHALL go to DONE.
REQ-027 DONE SHALL pulse o_done for 1 cycle, then go to IDLE.
REQ-028 Each cell SHALL take 11 cycles, so if i_start is accepted at edge k, o_done is high in cycle k+1+11*FIELD_W*FIELD_H.
REQ-029 o_busy SHALL be 1 in READ, DRAIN and WRITE, and 0 in IDLE and DONE.
REQ-030 o_alive_cnt SHALL hold its value after DONE until the next accepted i_start.
REQ-031 The rd and wr strobes SHALL never both be high in the same cycle.

Reset
REQ-032 i_rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-scan.
REQ-033 While in reset, all outputs and counters SHALL be 0, and no write SHALL follow the reset edge.

Structure
REQ-034 Package gol_pkg SHALL hold the state enum, NBR_SLOT_CNT=9, CYCLES_PER_CELL=11, BIRTH_MASK=9'b000001000 and SURVIVE_MASK=9'b000001100.
REQ-035 The next-state rule SHALL be derived from the BIRTH_MASK and SURVIVE_MASK package constants.
REQ-036 The block SHALL instantiate exactly one get_nbrs_address sub-module, fed with the current cell address, for slot addresses and relevance.
REQ-037 The self slot SHALL bypass get_nbrs_address and use the cell address directly.

Verification (FIELD_W=5, FIELD_H=5, 1-cycle-latency memory model)
REQ-038 All-dead field, i_start pulse -> 25 writes all 0; o_done in cycle k+276; o_alive_cnt=0.
REQ-039 Vertical blinker at (2,1),(2,2),(2,3) -> live writes exactly at (1,2),(2,2),(3,2); o_alive_cnt=3.
REQ-040 2x2 block at (0,0)-(1,1) -> the same 4 cells are written live; o_alive_cnt=4.
REQ-041 Cell (0,0) -> o_rd_en high only in slots 4, 6, 7 and 8.
REQ-042 Cell (4,4) -> o_rd_en high only in slots 0, 1, 3 and 8.
REQ-043 i_rst_n=0 for 1 cycle at cell 7 -> next cycle in IDLE with all outputs 0 and no further o_wr_en.
REQ-044 After a new i_start, the scan SHALL restart at (0,0).
REQ-045 i_start re-pulsed while o_busy=1 -> no effect; o_done timing unchanged.
